eth_rx_frame: RTL and testbench
===============================

# eth_rx_frame

Receive-side GMII frame parser that sits directly downstream of the RGMII-to-GMII DDR receiver, in the `gmii_rxc` domain. It consumes the byte-wide `gmii_rx_en`/`gmii_rxd` stream and locates preamble and SFD. It strips the FCS through a 4-byte delay line, checks CRC-32 and frame length, and presents payload bytes as a valid/sof/eof/err beat stream with per-frame good/bad counters.

## Interface
- `MIN_FRAME_LEN`, default 64: minimum legal bytes after SFD, FCS included.
- `MAX_FRAME_LEN`, default 1518: maximum legal bytes after SFD, FCS included.
- `CNT_W`, default 16: width of the frame counters.
- `gmii_rxc` in 1: the single clock (125 MHz GMII receive clock).
- `rst` in 1: reset, synchronous, active-high.
- `gmii_rx_en` in 1: GMII receive data valid.
- `gmii_rxd` in 8: GMII receive byte.
- `rx_data` out 8: payload byte (destination MAC through last payload byte, FCS removed).
- `rx_valid` out 1: `rx_data` is valid this cycle.
- `rx_sof` out 1: first beat of a frame; qualified by `rx_valid`.
- `rx_eof` out 1: last beat of a frame; qualified by `rx_valid`.
- `rx_err` out 1: frame bad (CRC or length); meaningful only on the eof beat.
- `good_frame_cnt` out CNT_W: count of frames ended with `rx_err`=0; wraps.
- `bad_frame_cnt` out CNT_W: count of frames with `rx_err`=1 plus silently dropped runts; wraps.

## Operation
- **FSM states:** IDLE, PREAMBLE, DATA, DROP.
- **IDLE**
  - `en`=1 and `rxd`=0x55 → PREAMBLE.
  - `en`=1 with any other byte → DROP.
- **PREAMBLE**
  - 0x55 → stay.
  - 0xD5 → DATA.
  - Any other byte → DROP.
  - `en`=0 → IDLE with no output and no count.
- **DATA**
  - Each `en`=1 byte is pushed into a 4-byte delay line and into the CRC.
  - `byte_cnt` increments and saturates at MAX_FRAME_LEN+1.
  - `en`=0 ends the frame → IDLE.
- **DROP:** wait for `en`=0, then go to IDLE. No output, no count.
- **Beat emission**
  - Byte i (0 = first byte after SFD) is emitted once the sample at position i+5 has been taken. That sample is either a data byte or the terminating `en`=0 cycle.
  - The beat carrying the last payload byte has `rx_eof`=1.
  - The first emitted beat has `rx_sof`=1. A frame with a 5-byte total has sof=eof on the same beat.
- **Runt:** a total below 5 bytes after SFD emits no beats and increments `bad_frame_cnt` only.
- **`rx_err` on eof** = CRC bad, OR `byte_cnt` < MIN_FRAME_LEN, OR `byte_cnt` > MAX_FRAME_LEN. Oversize frames keep emitting until `en`=0.
- **CRC-32**
  - Reflected polynomial 0xEDB88320, LSB first.
  - Initialised to 0xFFFFFFFF at SFD.
  - Computed over all bytes after SFD including FCS.
  - Good iff the register equals the residue 0xDEBB20E3 after the last byte.
- **Counters:** exactly one counter increments per completed DATA frame, in the eof cycle (runt: in the `en`-low cycle).
- **Back-to-back:** the FSM reaches IDLE in the `en`-low cycle, so a 1-cycle inter-frame gap is accepted. Preamble of the next frame is not output.

## Timing
- All outputs are registered.
- **Reset values:** `rx_data`=0x00, `rx_valid`/`rx_sof`/`rx_eof`/`rx_err`=0, counters=0, FSM=IDLE, delay line and CRC cleared.
- **Latency:** byte i appears one cycle after the edge sampling position i+5. The eof beat appears one cycle after the first `en`=0 sample.
- **No backpressure:** `rx_valid` has no ready; the consumer must accept every beat.
- **Reset mid-frame:** outputs drop to reset values in the following cycle, no eof is emitted, and counters are cleared. If `en`=1 when reset releases, the FSM goes to DROP until `en`=0.

## Configuration
- Macro: `ETH_RX_CRC_CHECK_EN`.
- **Defined:** CRC sub-module instantiated; CRC failure sets `rx_err`.
- **Undefined:** no CRC logic is built; `rx_err` reflects length checks only. The FCS is still stripped and latency is unchanged.

## Structure
- **Package `eth_pkg`:**
  - `ETH_PREAMBLE`=0x55, `ETH_SFD`=0xD5.
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_RESIDUE`.
  - FSM state typedef.
- **Sub-module `crc32_d8`:**
  - Combinational next-CRC of one byte plus a register with sync init and enable.
  - Reusable by the future transmit FCS generator.

## Test plan
- **Good minimal frame:** 7×0x55, 0xD5, 60 payload bytes, valid FCS → 60 beats, sof on beat 0, eof on beat 59, `rx_err`=0, `good_frame_cnt`=1.
- **Bad FCS:** same frame with FCS byte 0 XOR 0x01 → 60 beats, `rx_err`=1 on eof, `bad_frame_cnt`=1. With the macro undefined: `rx_err`=0.
- **Runt and undersize:**
  - 3 bytes after SFD → no beats, `bad_frame_cnt`+1.
  - 40-byte frame with valid CRC → 36 beats, `rx_err`=1.
- **Malformed preamble:**
  - 0x55,0x55,0x12,... → DROP, no beats, no counts.
  - 0x55 run ending with `en`=0 → no counts.
- **Back-to-back:** two 64-byte good frames separated by 1 `en`-low cycle → 120 beats, two sof/eof pairs, `good_frame_cnt`=2.
- **Reset mid-frame:** assert `rst` at payload byte 20 of a 100-byte frame, release while `en`=1 → no eof, counters 0. Next good frame is received correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and the byte-wise CRC-32 step for the Ethernet datapath.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  // One byte of reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    // NOTE: blocking '=' is correct here: each bit step must see the previous
    // step's result within the same evaluation. Clocked state uses '<=' only.
    c = crc;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ data[b]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_crc32_d8.sv
// crc32_d8: byte-wide CRC-32 register with synchronous init and enable.
// Kept generic so the transmit FCS generator can reuse it.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_nxt;

  assign crc_nxt = crc32_next(crc, data);

  always_ff @(posedge clk) begin
    if (rst)       crc <= '0;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc_nxt;
  end

endmodule

// File: rtl/eth_rx_frame.sv
// eth_rx_frame: GMII receive parser - strips preamble/SFD and FCS, checks length and
// (when ETH_RX_CRC_CHECK_EN is defined) CRC-32, and emits a sof/eof/err beat stream.
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 16
) (
  input  logic             gmii_rxc,
  input  logic             rst,
  input  logic             gmii_rx_en,
  input  logic [7:0]       gmii_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_err,
  output logic [CNT_W-1:0] good_frame_cnt,
  output logic [CNT_W-1:0] bad_frame_cnt
);

  localparam int BCNT_W  = $clog2(MAX_FRAME_LEN + 2);
  localparam int DLY_LEN = 5;  // four FCS bytes held back plus the byte being emitted
  localparam logic [BCNT_W-1:0] CNT_FIRST_BEAT = BCNT_W'(DLY_LEN);
  localparam logic [BCNT_W-1:0] CNT_MIN        = BCNT_W'(MIN_FRAME_LEN);
  localparam logic [BCNT_W-1:0] CNT_MAX        = BCNT_W'(MAX_FRAME_LEN);
  localparam logic [BCNT_W-1:0] CNT_SAT        = BCNT_W'(MAX_FRAME_LEN + 1);

  rx_state_t         state, state_nxt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [7:0]        dly [DLY_LEN];
  logic              post_rst;
  logic              sfd_seen, data_push, frame_end, beat;
  logic              crc_bad, len_bad, frame_bad;

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (gmii_rx_en)
          state_nxt = (!post_rst && gmii_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
      ST_PREAMBLE:
        if (!gmii_rx_en)                 state_nxt = ST_IDLE;
        else if (gmii_rxd == ETH_SFD)    state_nxt = ST_DATA;
        else if (gmii_rxd != ETH_PREAMBLE) state_nxt = ST_DROP;
      ST_DATA:
        if (!gmii_rx_en) state_nxt = ST_IDLE;
      ST_DROP:
        if (!gmii_rx_en) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  assign sfd_seen  = (state == ST_PREAMBLE) && gmii_rx_en && (gmii_rxd == ETH_SFD);
  assign data_push = (state == ST_DATA) && gmii_rx_en;
  assign frame_end = (state == ST_DATA) && !gmii_rx_en;
  assign beat      = (data_push || frame_end) && (byte_cnt >= CNT_FIRST_BEAT);
  assign len_bad   = (byte_cnt < CNT_MIN) || (byte_cnt > CNT_MAX);
  assign frame_bad = crc_bad || len_bad;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q;

  crc32_d8 u_crc (
    .clk  (gmii_rxc),
    .rst  (rst),
    .init (sfd_seen),
    .en   (data_push),
    .data (gmii_rxd),
    .crc  (crc_q)
  );

  assign crc_bad = (crc_q != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge gmii_rxc) begin
    if (rst) begin
      state          <= ST_IDLE;
      post_rst       <= 1'b1;
      byte_cnt       <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_sof         <= 1'b0;
      rx_eof         <= 1'b0;
      rx_err         <= 1'b0;
      good_frame_cnt <= '0;
      bad_frame_cnt  <= '0;
      // NOTE: the five-entry delay line is plain flops, so it is cleared with everything
      // else; a RAM-backed buffer would normally be left unreset.
      for (int i = 0; i < DLY_LEN; i++) dly[i] <= '0;
    end else begin
      state    <= state_nxt;
      post_rst <= 1'b0;

      rx_valid <= beat;
      rx_sof   <= beat && (byte_cnt == CNT_FIRST_BEAT);
      rx_eof   <= beat && frame_end;
      rx_err   <= beat && frame_end && frame_bad;
      if (beat) rx_data <= dly[DLY_LEN-1];

      if (sfd_seen)                            byte_cnt <= '0;
      else if (data_push && byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 1'b1;

      if (data_push) begin
        dly[0] <= gmii_rxd;
        for (int i = 1; i < DLY_LEN; i++) dly[i] <= dly[i-1];
      end

      // Runts never produce an eof beat but still count as bad frames.
      if (frame_end) begin
        if (byte_cnt < CNT_FIRST_BEAT || frame_bad) bad_frame_cnt  <= bad_frame_cnt + 1'b1;
        else                                         good_frame_cnt <= good_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Directed bench for eth_rx_frame: good/bad FCS, runt/undersize/oversize, bad preamble,
// back-to-back frames and reset in mid-frame.
module tb_eth_rx_frame;

  localparam int CNT_W = 16;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic             gmii_rxc = 1'b0;
  logic             rst = 1'b1;
  logic             gmii_rx_en = 1'b0;
  logic [7:0]       gmii_rxd = 8'h00;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_sof, rx_eof, rx_err;
  logic [CNT_W-1:0] good_frame_cnt, bad_frame_cnt;

  eth_rx_frame #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .CNT_W(CNT_W)) dut (
    .gmii_rxc       (gmii_rxc),
    .rst            (rst),
    .gmii_rx_en     (gmii_rx_en),
    .gmii_rxd       (gmii_rxd),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_sof         (rx_sof),
    .rx_eof         (rx_eof),
    .rx_err         (rx_err),
    .good_frame_cnt (good_frame_cnt),
    .bad_frame_cnt  (bad_frame_cnt)
  );

  always #4 gmii_rxc = ~gmii_rxc;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } beat_t;

  beat_t      got_q[$];
  beat_t      exp_q[$];
  logic [7:0] tx_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cyc0 = 0;
  int exp_good = 0;
  int exp_bad = 0;

  always @(posedge gmii_rxc) cyc <= cyc + 1;

  always @(negedge gmii_rxc) begin : monitor
    beat_t b;
    if (rx_valid === 1'b1) begin
      b.data = rx_data; b.sof = rx_sof; b.eof = rx_eof; b.err = rx_err; b.cyc = cyc;
      got_q.push_back(b);
    end
  end

  task automatic drive(input logic en, input logic [7:0] d);
    @(negedge gmii_rxc);
    gmii_rx_en = en;
    gmii_rxd   = d;
  endtask

  // Payload of (total-4) bytes followed by a reference FCS sent LSB first.
  task automatic build_frame(input int total, input int seed, input logic flip_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    tx_q.delete();
    for (int i = 0; i < total - 4; i++) tx_q.push_back(8'((i * 13 + seed) & 255));
    c = 32'hFFFF_FFFF;
    foreach (tx_q[i]) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      if (k == 0 && flip_fcs) b = b ^ 8'h01;
      tx_q.push_back(b);
    end
  endtask

  task automatic expect_frame(input logic err);
    beat_t b;
    int n;
    n = tx_q.size() - 4;
    for (int k = 0; k < n; k++) begin
      b.data = tx_q[k]; b.sof = (k == 0); b.eof = (k == n - 1); b.err = err; b.cyc = 0;
      exp_q.push_back(b);
    end
    if (err) exp_bad++;
    else     exp_good++;
  endtask

  task automatic send_frame(input int gap);
    for (int k = 0; k < 7; k++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int k = 0; k < tx_q.size(); k++) begin
      @(negedge gmii_rxc);
      if (k == 0) cyc0 = cyc;
      gmii_rx_en = 1'b1;
      gmii_rxd   = tx_q[k];
    end
    repeat (gap) drive(1'b0, 8'h00);
  endtask

  function automatic int beat_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      if (got_q[k].data !== exp_q[k].data || got_q[k].sof !== exp_q[k].sof ||
          got_q[k].eof !== exp_q[k].eof || (exp_q[k].eof && got_q[k].err !== exp_q[k].err))
        return k;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 8'h00);
    vectors++;
    if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {rx_valid, rx_sof, rx_eof, rx_err});
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 00", rx_data);
    end
    vectors++;
    if (good_frame_cnt !== '0 || bad_frame_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt: got good=%0d bad=%0d expected 0/0", good_frame_cnt, bad_frame_cnt);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00);
  endtask

  task automatic test_good_min();
    int d;
    start_test();
    build_frame(64, 1, 1'b0);
    expect_frame(1'b0);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL good_min beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (got_q.size() > 0 && got_q[0].cyc !== cyc0 + 6) begin
      miscompares++;
      $display("FAIL good_min sof_latency: got cycle %0d expected %0d", got_q[0].cyc, cyc0 + 6);
    end
    vectors++;
    if (got_q.size() > 0 && got_q[got_q.size()-1].cyc !== cyc0 + 65) begin
      miscompares++;
      $display("FAIL good_min eof_latency: got cycle %0d expected %0d", got_q[got_q.size()-1].cyc, cyc0 + 65);
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL good_min cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_bad_fcs();
    int d;
    start_test();
    build_frame(64, 1, 1'b1);
    expect_frame(CRC_ON);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL bad_fcs beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL bad_fcs cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_runt_undersize();
    int d;
    start_test();
    tx_q.delete();
    tx_q.push_back(8'hA1); tx_q.push_back(8'hB2); tx_q.push_back(8'hC3);
    exp_bad++;
    send_frame(4);
    vectors++;
    if (got_q.size() !== 0 || bad_frame_cnt !== CNT_W'(exp_bad) || good_frame_cnt !== CNT_W'(exp_good)) begin
      miscompares++;
      $display("FAIL runt: got %0d beats cnt %0d/%0d expected 0 beats cnt %0d/%0d",
               got_q.size(), good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
    start_test();
    build_frame(40, 2, 1'b0);
    expect_frame(1'b1);
    build_frame(5, 4, 1'b0);
    expect_frame(1'b1);
    build_frame(40, 2, 1'b0);
    send_frame(3);
    build_frame(5, 4, 1'b0);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL undersize beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL undersize cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_length_limits();
    int d;
    start_test();
    build_frame(1518, 6, 1'b0);
    expect_frame(1'b0);
    send_frame(2);
    build_frame(1519, 8, 1'b0);
    expect_frame(1'b1);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL length_limits beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL length_limits cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_bad_preamble();
    start_test();
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h12);
    for (int k = 0; k < 12; k++) drive(1'b1, (k == 5) ? 8'hD5 : 8'h55);
    drive(1'b0, 8'h00);
    for (int k = 0; k < 6; k++) drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hD5);
    for (int k = 0; k < 10; k++) drive(1'b1, 8'(k));
    repeat (4) drive(1'b0, 8'h00);
    vectors++;
    if (got_q.size() !== 0) begin
      miscompares++;
      $display("FAIL bad_preamble beats: got %0d expected 0", got_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL bad_preamble cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    start_test();
    build_frame(64, 3, 1'b0);
    expect_frame(1'b0);
    send_frame(1);
    build_frame(64, 9, 1'b0);
    expect_frame(1'b0);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL back_to_back beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL back_to_back cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    beat_t b;
    int d;
    start_test();
    build_frame(100, 5, 1'b0);
    // Positions 5..19 are sampled before reset, so payload bytes 0..14 escape; no eof.
    for (int k = 0; k < 15; k++) begin
      b.data = tx_q[k]; b.sof = (k == 0); b.eof = 1'b0; b.err = 1'b0; b.cyc = 0;
      exp_q.push_back(b);
    end
    exp_good = 0;
    exp_bad  = 0;
    for (int k = 0; k < 7; k++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int k = 0; k < tx_q.size(); k++) begin
      @(negedge gmii_rxc);
      if (k == 20) rst = 1'b1;
      if (k == 23) rst = 1'b0;
      gmii_rx_en = 1'b1;
      gmii_rxd   = tx_q[k];
    end
    repeat (4) drive(1'b0, 8'h00);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL reset_mid beats: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== '0 || bad_frame_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_mid cnt: got %0d/%0d expected 0/0", good_frame_cnt, bad_frame_cnt);
    end
    start_test();
    build_frame(64, 7, 1'b0);
    expect_frame(1'b0);
    send_frame(4);
    d = beat_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL reset_mid next_frame: differs at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (good_frame_cnt !== CNT_W'(exp_good) || bad_frame_cnt !== CNT_W'(exp_bad)) begin
      miscompares++;
      $display("FAIL reset_mid next_cnt: got %0d/%0d expected %0d/%0d", good_frame_cnt, bad_frame_cnt, exp_good, exp_bad);
    end
  endtask

  initial begin
    test_reset();
    test_good_min();
    test_bad_fcs();
    test_runt_undersize();
    test_length_limits();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
